// File: rtl/conv1d_mac.sv
// conv1d_mac: sequential 1D convolution (FIR) core.
// Shifts one signed sample per input handshake into a KLEN-deep window, then
// accumulates window*coef with a single multiplier over KLEN cycles and
// presents the sum on a valid/ready output.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   coef_we    coefficient write strobe (honoured only in IDLE)
//   coef_addr  coefficient index; values >= KLEN are ignored
//   coef_data  signed coefficient
//   in_valid   sample valid
//   in_ready   core can accept a sample (IDLE only)
//   in_data    signed sample
//   out_valid  result valid (OUT state)
//   out_ready  consumer accepts result
//   out_data   signed result, held until the next result is loaded
//   busy       high whenever the core is not IDLE
module conv1d_mac #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned KLEN   = 5,
  parameter int unsigned ACC_W  = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coef_we,
  input  logic [2:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy
);

  localparam int unsigned ProdW = DATA_W + COEF_W;

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] win_q  [KLEN];
  logic signed [COEF_W-1:0] coef_q [KLEN];
  logic signed [ACC_W-1:0]  acc_q, acc_d, out_q;
  logic [2:0]               idx_q;

  logic                     accept, last;
  logic signed [DATA_W-1:0] win_sel;
  logic signed [COEF_W-1:0] coef_sel;
  logic signed [ProdW-1:0]  prod;

  assign accept = in_valid && (state_q == StIdle);
  assign last   = (idx_q == 3'(KLEN - 1));

  // Tap select: idx never exceeds KLEN-1 while in MAC.
  always_comb begin
    win_sel  = '0;
    coef_sel = '0;
    for (int unsigned i = 0; i < KLEN; i++) begin
      if (idx_q == 3'(i)) begin
        win_sel  = win_q[i];
        coef_sel = coef_q[i];
      end
    end
  end

  // Size casts of signed operands sign-extend, giving a full-precision product.
  assign prod  = ProdW'(win_sel) * ProdW'(coef_sel);
  assign acc_d = acc_q + ACC_W'(prod);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StMac;
      StMac:   if (last)      state_d = StOut;
      StOut:   if (out_ready) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      for (int unsigned i = 0; i < KLEN; i++) begin
        win_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        win_q[0] <= in_data;
        for (int unsigned i = 1; i < KLEN; i++) begin
          win_q[i] <= win_q[i-1];
        end
        acc_q <= '0;
        idx_q <= '0;
      end else if (state_q == StMac) begin
        acc_q <= acc_d;
        idx_q <= idx_q + 3'd1;
        // Separate result register so out_data survives the next accept.
        if (last) out_q <= acc_d;
      end
      // Out-of-range addresses match no tap and are dropped.
      if ((state_q == StIdle) && coef_we) begin
        for (int unsigned i = 0; i < KLEN; i++) begin
          if (coef_addr == 3'(i)) coef_q[i] <= coef_data;
        end
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_q;

endmodule

// File: tb/tb_conv1d_mac.sv
// Directed self-checking bench for conv1d_mac (KLEN=5, 8-bit data/coef).
module tb_conv1d_mac;

  localparam int KLEN = 5;

  logic              clk;
  logic              reset;
  logic              coef_we;
  logic [2:0]        coef_addr;
  logic [7:0]        coef_data;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [18:0]       out_data;
  logic              busy;

  int n_chk = 0;
  int n_bad = 0;

  conv1d_mac #(
    .DATA_W(8),
    .COEF_W(8),
    .KLEN  (KLEN),
    .ACC_W (19)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_coef(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = 3'(a);
    coef_data = 8'(d);
    @(posedge clk); #1;
    coef_we   = 1'b0;
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2, input int c3,
                            input int c4);
    write_coef(0, c0);
    write_coef(1, c1);
    write_coef(2, c2);
    write_coef(3, c3);
    write_coef(4, c4);
  endtask

  // Called #1 after an accept edge; cycles already spent count toward latency.
  task automatic wait_out(input string tag, input int spent, input longint exp_y);
    int n;
    n = spent;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, KLEN);
    chk(tag, $signed(out_data), exp_y);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_pulse"}, out_valid, 0);
      chk({tag, "_rdy"}, in_ready, 1);
    end
  endtask

  task automatic send(input string tag, input int v, input longint exp_y);
    int n;
    in_valid = 1'b1;
    in_data  = 8'(v);
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(tag, 0, exp_y);
  endtask

  initial begin
    int n, k, nout, cnt;
    bit take;
    int acc_t [3];
    int smp   [3];
    int ey    [3];

    reset     = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    #9 reset = 1'b1;
    @(posedge clk); #1;

    // Impulse response walks the coefficient bank.
    load_coefs(1, 2, 3, 4, 5);
    send("imp0", 1, 1);
    send("imp1", 0, 2);
    send("imp2", 0, 3);
    send("imp3", 0, 4);
    send("imp4", 0, 5);
    send("imp5", 0, 0);

    // Signed extremes; window is all zero again here.
    load_coefs(-128, -128, -128, -128, -128);
    send("ext1", -128, 16384);
    send("ext2", -128, 32768);
    send("ext3", -128, 49152);
    send("ext4", -128, 65536);
    send("ext5", -128, 81920);
    load_coefs(127, 0, 0, 0, 0);
    send("ext_neg", -128, -16256);

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    send("bp", 2, 254);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_data", $signed(out_data), 254);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_valid", out_valid, 0);
    chk("bp_rel_idle", in_ready, 1);
    chk("bp_rel_busy", busy, 0);
    chk("bp_hold_data", $signed(out_data), 254);

    // Coefficient write during MAC is ignored: 127*3.
    in_valid = 1'b1;
    in_data  = 8'sd3;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 8'd9;
    repeat (2) @(posedge clk);
    #1;
    coef_we = 1'b0;
    wait_out("we_mac", 2, 381);

    // Out-of-range address in IDLE is ignored: window [1,3,2,-128,-128].
    write_coef(6, 9);
    send("we_oob", 1, 127);

    // Write and accept in the same cycle: new coef used, window [4,1,3,2,-128].
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 8'd9;
    in_valid  = 1'b1;
    in_data   = 8'sd4;
    @(posedge clk); #1;
    coef_we  = 1'b0;
    in_valid = 1'b0;
    wait_out("we_acc", 0, 36);

    // Reset two cycles into MAC.
    in_valid = 1'b1;
    in_data  = 8'sd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_busy_pre", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_out_data", out_data, 0);
    #4 reset = 1'b1;
    @(posedge clk); #1;
    load_coefs(1, 2, 3, 4, 5);
    send("mid_imp", 1, 1);

    // Continuous in_valid: window [1,0,0,0,0] before the stream.
    smp = '{2, 3, 4};
    ey  = '{4, 10, 20};
    in_valid = 1'b1;
    in_data  = 8'(smp[0]);
    k = 0;
    nout = 0;
    cnt = 0;
    while (nout < 3 && cnt < 100) begin
      take = in_valid && in_ready;
      @(posedge clk); #1;
      cnt++;
      if (take) begin
        acc_t[k] = cnt;
        k++;
        if (k < 3) in_data = 8'(smp[k]);
        else       in_valid = 1'b0;
      end
      if (out_valid) begin
        chk("pace_y", $signed(out_data), ey[nout]);
        nout++;
      end
    end
    in_valid = 1'b0;
    chk("pace_nout", nout, 3);
    chk("pace_nacc", k, 3);
    if (k == 3) begin
      chk("pace_gap1", acc_t[1] - acc_t[0], 7);
      chk("pace_gap2", acc_t[2] - acc_t[1], 7);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
